rs_syndrome_calc: RTL and testbench
===================================

RS_SYNDROME_CALC -- requirements
Module: rs_syndrome_calc

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: single system clock, all logic on rising edge.
REQ-002 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port new_cvcdu, input, 1 bit: the byte presented this cycle is the first byte of a new codeword.
REQ-004 SHALL have port byte_in, input, 8 bits: received codeword byte, conventional basis.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-006 SHALL have port byte_ready, output, 1 bit: block can accept a byte.
REQ-007 SHALL have port syndrome, output, 8 bits: current syndrome value.
REQ-008 SHALL have port syndrome_idx, output, 5 bits: index 0..31 of the presented syndrome (root j = 112 + idx).
REQ-009 SHALL have port syndrome_valid, output, 1 bit: syndrome and syndrome_idx are valid.
REQ-010 SHALL have port syndrome_ready, input, 1 bit: downstream Berlekamp-Massey stage accepts the syndrome.
REQ-011 SHALL have port syndrome_last, output, 1 bit: asserted together with idx 31.

Function
REQ-012 SHALL compute S_idx = r(beta^(112+idx)) for idx 0..31, with beta = alpha^11, over GF(256) with field polynomial x^8+x^7+x^2+x+1.
REQ-013 SHALL treat the first accepted byte as the x^254 coefficient and the 255th as the x^0 coefficient.
REQ-014 SHALL update all 32 accumulators in parallel by Horner's rule on each accepted byte: S <- S*beta^(112+idx) XOR byte_in.
REQ-015 SHALL accept a byte only on cycles where byte_valid and byte_ready are both high.
REQ-016 SHALL use an FSM with the states IDLE, ACCUM and OUTPUT.
REQ-017 IDLE: byte_ready=1; an accepted byte with new_cvcdu=1 SHALL load accumulators with byte_in, set the byte count to 1 and move to ACCUM; accepted bytes without new_cvcdu SHALL be ignored.
REQ-018 ACCUM: byte_ready=1; each accepted byte SHALL increment the count; the accepted byte that brings the count to 255 SHALL move the FSM to OUTPUT in the next cycle.
REQ-019 An accepted byte in ACCUM with new_cvcdu=1 SHALL discard the partial codeword and restart with the count at 1, accumulators = byte_in.
REQ-020 OUTPUT: byte_ready=0 and syndrome_valid=1; the first syndrome (idx 0) SHALL be presented in the cycle after the 255th byte is accepted.
REQ-021 OUTPUT: the index SHALL advance on each cycle with syndrome_valid and syndrome_ready both high; syndrome and syndrome_idx SHALL hold stable while syndrome_ready is low.
REQ-022 The handshake on idx 31 (with syndrome_last=1) SHALL return the FSM to IDLE; the block SHALL accept the next codeword in the following cycle.
REQ-023 Throughput: minimum 255 + 32 cycles per codeword with no backpressure.

Reset
REQ-024 When rst_in is low, the block SHALL asynchronously force state=IDLE, count=0, idx=0, all accumulators=0, syndrome=0, syndrome_valid=0 and syndrome_last=0, with byte_ready=1 once rst_in is released.
REQ-025 Reset mid-codeword or mid-output SHALL discard all data; no partial syndromes SHALL be emitted afterwards.

Configuration
REQ-026 When RS_SYN_ZERO_FLAG_EN is defined, the block SHALL add output syn_zero (1 bit); it SHALL be high with syndrome_last exactly when all 32 syndromes are 0, low otherwise, and reset to 0.
REQ-027 When RS_SYN_ZERO_FLAG_EN is undefined, the syn_zero port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 The shared package rs_pkg SHALL hold GF_POLY (8'h87), RS_N (255), RS_NROOTS (32), RS_FCR (112), RS_PRIM (11) and the FSM state typedef.
REQ-029 One sub-module rs_gf_mul_const SHALL implement combinational multiplication by a parameterised GF(256) constant; it SHALL be instantiated 32 times through a generate loop.

Verification
REQ-030 All-zero codeword -> 32 syndromes of 0x00, idx 0..31 in order, syndrome_last on idx 31 (syn_zero=1 when RS_SYN_ZERO_FLAG_EN is defined).
REQ-031 Codeword with 0x01 only in byte 255 (x^0) -> all 32 syndromes = 0x01.
REQ-032 Valid CCSDS codeword from the reference encoder with byte 10 XOR 0x5A -> syndromes match the software model; without the error -> all 0x00.
REQ-033 syndrome_ready held low for 5 cycles at idx 3 -> idx 3 and its value held stable; byte_ready=0 throughout OUTPUT.
REQ-034 new_cvcdu reasserted at byte 100 -> syndromes correspond only to the new 255-byte codeword.
REQ-035 rst_in pulsed low during OUTPUT at idx 10 -> outputs zero immediately, state IDLE, next codeword processed correctly.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants, FSM state type and GF(256) helpers for the RS(255,223)
// syndrome calculator. Field polynomial x^8+x^7+x^2+x+1, alpha = x.
package rs_pkg;

    localparam logic [7:0] GF_POLY   = 8'h87;
    localparam int         RS_N      = 255;
    localparam int         RS_NROOTS = 32;
    localparam int         RS_FCR    = 112;
    localparam int         RS_PRIM   = 11;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } rs_state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < (e % RS_N); i++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    // Root evaluated by syndrome idx: beta^(FCR+idx) with beta = alpha^PRIM.
    function automatic logic [7:0] rs_root(input int idx);
        return gf_alpha_pow(RS_PRIM * (RS_FCR + idx));
    endfunction

endpackage

// File: rtl/rs_gf_mul_const.sv
// Combinational GF(256) multiplication of an operand by a constant K,
// built as a shift-and-XOR over the operand bits.
module rs_gf_mul_const
    import rs_pkg::*;
#(
    parameter logic [7:0] K = 8'h01
) (
    input  logic [7:0] a,
    output logic [7:0] p
);

    always_comb begin
        logic [7:0] k_shift;
        // NOTE: every variable written here gets a value before any branch so no latch is inferred.
        p       = 8'h00;
        k_shift = K;
        for (int b = 0; b < 8; b++) begin
            if (a[b]) begin
                p ^= k_shift;
            end
            k_shift = gf_xtime(k_shift);
        end
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(255,223) syndrome calculator: 32 parallel Horner accumulators, then a
// valid/ready stream of syndromes. Optional syn_zero output: RS_SYN_ZERO_FLAG_EN.
module rs_syndrome_calc
    import rs_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       new_cvcdu,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [7:0] syndrome,
    output logic [4:0] syndrome_idx,
    output logic       syndrome_valid,
    input  logic       syndrome_ready,
`ifdef RS_SYN_ZERO_FLAG_EN
    output logic       syn_zero,
`endif
    output logic       syndrome_last
);

    rs_state_t  state, state_nxt;
    logic [7:0] count;
    logic [4:0] idx;
    logic [7:0] acc     [RS_NROOTS];
    logic [7:0] acc_mul [RS_NROOTS];
    logic       accept;
    logic       load;

    assign byte_ready     = (state != OUTPUT);
    assign accept         = byte_valid && byte_ready;
    assign load           = accept && new_cvcdu;
    assign syndrome_valid = (state == OUTPUT);
    assign syndrome_last  = syndrome_valid && (idx == 5'd31);
    assign syndrome_idx   = idx;
    assign syndrome       = syndrome_valid ? acc[idx] : 8'h00;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = ACCUM;
            ACCUM:   if (accept && !new_cvcdu && count == 8'(RS_N - 1)) state_nxt = OUTPUT;
            OUTPUT:  if (syndrome_ready && syndrome_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    generate
        for (genvar i = 0; i < RS_NROOTS; i++) begin : g_root
            rs_gf_mul_const #(.K(rs_root(i))) u_mul (
                .a (acc[i]),
                .p (acc_mul[i])
            );
        end
    endgenerate

    // A new_cvcdu byte always restarts the codeword, even mid-accumulation.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= 8'd0;
            idx   <= 5'd0;
            // NOTE: the accumulator bank is reset explicitly so a reset can never leak stale syndromes.
            for (int i = 0; i < RS_NROOTS; i++) begin
                acc[i] <= 8'h00;
            end
        end else begin
            if (load) begin
                count <= 8'd1;
                for (int i = 0; i < RS_NROOTS; i++) begin
                    acc[i] <= byte_in;
                end
            end else if (accept && state == ACCUM) begin
                count <= count + 8'd1;
                for (int i = 0; i < RS_NROOTS; i++) begin
                    acc[i] <= acc_mul[i] ^ byte_in;
                end
            end
            if (syndrome_valid && syndrome_ready) begin
                idx <= idx + 5'd1;
            end
        end
    end

`ifdef RS_SYN_ZERO_FLAG_EN
    logic acc_any;

    always_comb begin
        acc_any = 1'b0;
        for (int i = 0; i < RS_NROOTS; i++) begin
            acc_any = acc_any | (|acc[i]);
        end
    end

    assign syn_zero = syndrome_last && !acc_any;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: table-based GF(256) model, reference
// RS encoder and direct polynomial evaluation for expected syndromes.
module tb_rs_syndrome_calc;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       new_cvcdu;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] syndrome;
    logic [4:0] syndrome_idx;
    logic       syndrome_valid;
    logic       syndrome_ready;
    logic       syndrome_last;
`ifdef RS_SYN_ZERO_FLAG_EN
    logic       syn_zero;
`endif

    rs_syndrome_calc dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .new_cvcdu      (new_cvcdu),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .syndrome       (syndrome),
        .syndrome_idx   (syndrome_idx),
        .syndrome_valid (syndrome_valid),
        .syndrome_ready (syndrome_ready),
`ifdef RS_SYN_ZERO_FLAG_EN
        .syn_zero       (syn_zero),
`endif
        .syndrome_last  (syndrome_last)
    );

    always #5 clk_in = ~clk_in;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_t   [256];
    int         log_t   [256];
    logic [7:0] gen     [33];
    logic [7:0] cw      [255];
    logic [7:0] exp_syn [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic logic [7:0] root(input int j);
        return exp_t[(11 * (112 + j)) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h87 : 8'h00);
        end
        exp_t[255] = 8'h01;
        log_t[0]   = 0;
        for (int i = 0; i < 33; i++) gen[i] = 8'h00;
        gen[0] = 8'h01;
        for (int j = 0; j < 32; j++) begin
            for (int i = 32; i >= 1; i--) gen[i] = gen[i-1] ^ gf_mul(root(j), gen[i]);
            gen[0] = gf_mul(root(j), gen[0]);
        end
    endtask

    // Systematic encoder: 223 random data bytes then 32 parity bytes.
    task automatic encode();
        logic [7:0] par [32];
        logic [7:0] fb;
        for (int i = 0; i < 32; i++) par[i] = 8'h00;
        for (int k = 0; k < 223; k++) begin
            cw[k] = 8'($urandom);
            fb = cw[k] ^ par[31];
            for (int i = 31; i >= 1; i--) par[i] = par[i-1] ^ gf_mul(fb, gen[i]);
            par[0] = gf_mul(fb, gen[0]);
        end
        for (int k = 0; k < 32; k++) cw[223 + k] = par[31 - k];
    endtask

    // Direct evaluation: byte k is the coefficient of x^(254-k).
    task automatic compute_model();
        for (int j = 0; j < 32; j++) begin
            exp_syn[j] = 8'h00;
            for (int k = 0; k < 255; k++) begin
                exp_syn[j] ^= gf_mul(cw[k], exp_t[(11 * (112 + j) * (254 - k)) % 255]);
            end
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int j = 0; j < 32; j++) exp_syn[j] = v;
    endtask

    task automatic feed(input int garbage_n);
        for (int k = 0; k < garbage_n; k++) begin
            byte_valid = 1'b1;
            new_cvcdu  = (k == 0);
            byte_in    = 8'($urandom);
            @(negedge clk_in);
        end
        for (int k = 0; k < 255; k++) begin
            if (k == 0 || k == 254) check($sformatf("byte_ready feed[%0d]", k), 32'(byte_ready), 32'd1);
            byte_valid = 1'b1;
            new_cvcdu  = (k == 0);
            byte_in    = cw[k];
            @(negedge clk_in);
        end
        byte_valid = 1'b0;
        new_cvcdu  = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic collect(input int n, input int stall_at);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 0; j < 32; j++) if (exp_syn[j] != 8'h00) all_zero = 1'b0;
        syndrome_ready = 1'b1;
        for (int j = 0; j < n; j++) begin
            check($sformatf("valid[%0d]", j), 32'(syndrome_valid), 32'd1);
            check($sformatf("idx[%0d]", j), 32'(syndrome_idx), 32'(j));
            check($sformatf("syn[%0d]", j), 32'(syndrome), 32'(exp_syn[j]));
            check($sformatf("last[%0d]", j), 32'(syndrome_last), 32'(j == 31));
            check($sformatf("byte_ready out[%0d]", j), 32'(byte_ready), 32'd0);
`ifdef RS_SYN_ZERO_FLAG_EN
            check($sformatf("syn_zero[%0d]", j), 32'(syn_zero), 32'((j == 31) && all_zero));
`endif
            if (j == stall_at) begin
                syndrome_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk_in);
                    check("stall idx", 32'(syndrome_idx), 32'(j));
                    check("stall syn", 32'(syndrome), 32'(exp_syn[j]));
                    check("stall byte_ready", 32'(byte_ready), 32'd0);
                end
                syndrome_ready = 1'b1;
            end
            @(negedge clk_in);
        end
        if (n == 32) begin
            check("post valid", 32'(syndrome_valid), 32'd0);
            check("post byte_ready", 32'(byte_ready), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in         = 1'b0;
        new_cvcdu      = 1'b0;
        byte_in        = 8'h00;
        byte_valid     = 1'b0;
        syndrome_ready = 1'b0;
        build_tables();
        repeat (3) @(negedge clk_in);
        check("reset valid", 32'(syndrome_valid), 32'd0);
        check("reset syn", 32'(syndrome), 32'd0);
        check("reset last", 32'(syndrome_last), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("reset byte_ready", 32'(byte_ready), 32'd1);
        check("reset idx", 32'(syndrome_idx), 32'd0);

        // All-zero codeword, preceded by bytes without new_cvcdu that must be ignored.
        for (int k = 0; k < 5; k++) begin
            byte_valid = 1'b1;
            byte_in    = 8'hA5;
            @(negedge clk_in);
            check("idle ignore valid", 32'(syndrome_valid), 32'd0);
        end
        for (int k = 0; k < 255; k++) cw[k] = 8'h00;
        fill_const(8'h00);
        feed(0);
        collect(32, -1);

        // Single 0x01 in the x^0 position.
        cw[254] = 8'h01;
        fill_const(8'h01);
        feed(0);
        collect(32, -1);

        // Clean encoded codeword.
        encode();
        fill_const(8'h00);
        feed(0);
        collect(32, -1);

        // Same codeword with byte 10 corrupted, stalled at idx 3.
        cw[9] ^= 8'h5A;
        compute_model();
        check("model err nonzero", 32'(exp_syn[0] != 8'h00), 32'd1);
        feed(0);
        collect(32, 3);

        // Restart with new_cvcdu on stream byte 100.
        encode();
        cw[200] ^= 8'h33;
        compute_model();
        feed(99);
        collect(32, -1);

        // Reset pulsed at idx 10, then a fresh codeword.
        encode();
        cw[0] ^= 8'hC3;
        compute_model();
        feed(0);
        collect(10, -1);
        check("pre-reset idx", 32'(syndrome_idx), 32'd10);
        rst_in = 1'b0;
        #1;
        check("rst valid", 32'(syndrome_valid), 32'd0);
        check("rst syn", 32'(syndrome), 32'd0);
        check("rst idx", 32'(syndrome_idx), 32'd0);
        check("rst last", 32'(syndrome_last), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            check("post-rst valid", 32'(syndrome_valid), 32'd0);
            check("post-rst byte_ready", 32'(byte_ready), 32'd1);
        end
        encode();
        cw[120] ^= 8'h0F;
        compute_model();
        feed(0);
        collect(32, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
